// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO with block-RAM storage, optional
// first-word-fall-through output stage, occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and a
// synchronous flush. All flags decode from registered state only.
module fifo_sync_flags #(
  parameter int DW     = 8,
  parameter int AW     = 9,
  parameter int FWFT   = 0,
  parameter int AF_LVL = (1 << AW) - 4,
  parameter int AE_LVL = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int DEPTH = 1 << AW;
  // In FWFT mode the output stage holds one entry on top of the memory.
  localparam int CAP   = (FWFT != 0) ? DEPTH + 1 : DEPTH;

  localparam logic [AW:0] CAP_W = (AW+1)'(CAP);
  localparam logic [AW:0] AF_W  = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AE_W  = (AW+1)'(AE_LVL);
  localparam logic [AW:0] ONE   = (AW+1)'(1);

  // Storage and its registered read port.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_q_reg;

  // Bypass register: holds a word written straight into an idle FWFT output
  // stage, so the RAM output register never needs a data mux in front of it.
  logic [DW-1:0] byp_reg;
  logic          sel_byp_reg, sel_byp_next;

  // Pointers carry one extra bit so wrap phase is visible.
  logic [AW:0]   wptr_reg, wptr_next;
  logic [AW:0]   rptr_reg, rptr_next;
  logic [AW:0]   count_reg, count_next;
  logic          valid_reg, valid_next;
  logic          ovf_reg, ovf_next;
  logic          unf_reg, unf_next;

  // Per-cycle strobes.
  logic          rd_acc;
  logic          wr_acc;
  logic          ram_we;
  logic          ram_re;
  logic          byp_load;
  logic          mem_empty;

  // Flag decode from registered occupancy.
  assign full         = (count_reg == CAP_W);
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= AF_W);
  assign almost_empty = (count_reg <= AE_W);
  assign count        = count_reg;
  assign valid        = valid_reg;
  assign overflow     = ovf_reg;
  assign underflow    = unf_reg;
  assign dout         = sel_byp_reg ? byp_reg : ram_q_reg;

  // Accept/steer decisions and next-state for pointers, count, valid and flags.
  always_comb begin
    rd_acc       = 1'b0;
    wr_acc       = 1'b0;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    byp_load     = 1'b0;
    valid_next   = valid_reg;
    sel_byp_next = sel_byp_reg;
    count_next   = count_reg;

    // Memory-only occupancy is zero when the pointers coincide.
    mem_empty = (wptr_reg == rptr_reg);

    if (FWFT != 0) begin
      // A pop consumes whatever is currently presented on dout.
      rd_acc = rd && valid_reg;
    end else begin
      rd_acc = rd && !empty;
    end

    // A read accepted this cycle frees a slot for a write even when full.
    wr_acc = wr && (!full || rd_acc);

    if (FWFT != 0) begin
      // The output stage is free (or being freed with nothing behind it):
      // the incoming word skips the memory.
      byp_load = wr_acc && (!valid_reg || (rd_acc && mem_empty));
      ram_we   = wr_acc && !byp_load;
      // Refill the output stage from memory on every pop that has a successor.
      ram_re   = rd_acc && !mem_empty;

      if (byp_load || ram_re) begin
        valid_next = 1'b1;
      end else if (rd_acc) begin
        valid_next = 1'b0;
      end

      if (byp_load) begin
        sel_byp_next = 1'b1;
      end else if (ram_re) begin
        sel_byp_next = 1'b0;
      end
    end else begin
      ram_we       = wr_acc;
      ram_re       = rd_acc;
      valid_next   = rd_acc;
      sel_byp_next = 1'b0;
    end

    if (wr_acc && !rd_acc) begin
      count_next = count_reg + ONE;
    end else if (!wr_acc && rd_acc) begin
      count_next = count_reg - ONE;
    end

    wptr_next = ram_we ? wptr_reg + ONE : wptr_reg;
    rptr_next = ram_re ? rptr_reg + ONE : rptr_reg;
    ovf_next  = ovf_reg || (wr && !wr_acc);
    unf_next  = unf_reg || (rd && !rd_acc);

    // Flush wins over any read or write in the same cycle; dout is left alone.
    if (clr) begin
      ram_we       = 1'b0;
      ram_re       = 1'b0;
      byp_load     = 1'b0;
      sel_byp_next = sel_byp_reg;
      valid_next   = 1'b0;
      count_next   = '0;
      wptr_next    = '0;
      rptr_next    = '0;
      ovf_next     = 1'b0;
      unf_next     = 1'b0;
    end
  end

  // Memory write port; same-address read in the same cycle sees the old word.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[wptr_reg[AW-1:0]] <= din;
    end
  end

  // Registered memory read feeding dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_q_reg <= '0;
    end else if (ram_re) begin
      ram_q_reg <= mem[rptr_reg[AW-1:0]];
    end
  end

  // Bypass data capture and output source select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_reg     <= '0;
      sel_byp_reg <= 1'b0;
    end else begin
      if (byp_load) begin
        byp_reg <= din;
      end
      sel_byp_reg <= sel_byp_next;
    end
  end

  // Pointer, occupancy, qualifier and sticky error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      valid_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      wptr_reg  <= wptr_next;
      rptr_reg  <= rptr_next;
      count_reg <= count_next;
      valid_reg <= valid_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed-vector and scoreboard bench for fifo_sync_flags: one standard-mode
// instance and one FWFT instance, both AW=2.
module tb_fifo_sync_flags;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Standard-mode instance (CAP=4, AF=3, AE=1).
  logic       clr0, wr0, rd0;
  logic [7:0] din0, dout0;
  logic       valid0, full0, empty0, af0, ae0, ovf0, unf0;
  logic [2:0] count0;
  logic [5:0] fl0;

  // FWFT instance (CAP=5, AF=4, AE=1).
  logic       clr1, wr1, rd1;
  logic [7:0] din1, dout1;
  logic       valid1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [2:0] count1;
  logic [5:0] fl1;

  assign fl0 = {full0, empty0, af0, ae0, ovf0, unf0};
  assign fl1 = {full1, empty1, af1, ae1, ovf1, unf1};

  fifo_sync_flags #(.DW(8), .AW(2), .FWFT(0), .AF_LVL(3), .AE_LVL(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr0), .wr(wr0), .din(din0), .rd(rd0),
    .dout(dout0), .valid(valid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(unf0)
  );

  fifo_sync_flags #(.DW(8), .AW(2), .FWFT(1), .AF_LVL(4), .AE_LVL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr1), .wr(wr1), .din(din1), .rd(rd1),
    .dout(dout1), .valid(valid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(unf1)
  );

  // Expected outputs; fl = {full, empty, almost_full, almost_empty, overflow, underflow}.
  typedef struct packed {
    logic [7:0] dout;
    logic       valid;
    logic [2:0] count;
    logic [5:0] fl;
    logic       chk_dout;
  } exp_t;

  // ctl = {wr, rd, clr}
  typedef struct packed {
    logic [2:0] ctl;
    logic [7:0] din;
    exp_t       e;
  } vec_t;

  vec_t t0 [23];
  vec_t t1 [21];

  int n_vec  = 0;
  int n_miss = 0;

  string fl_name [6] = '{"full", "empty", "almost_full", "almost_empty", "overflow", "underflow"};

  function automatic exp_t ex(input logic [7:0] d, input logic v, input logic [2:0] c,
                              input logic [5:0] fl, input logic cd);
    return {d, v, c, fl, cd};
  endfunction

  function automatic vec_t vt(input logic [2:0] ctl, input logic [7:0] din, input exp_t e);
    return {ctl, din, e};
  endfunction

  task automatic cmp_field(input string tag, input string fld, input int act, input int exp);
    if (act != exp) begin
      $display("FAIL %s %s: got 0x%0h, expected 0x%0h", tag, fld, act, exp);
      n_miss++;
    end
  endtask

  task automatic check(input string tag, input exp_t e, input logic [7:0] d,
                       input logic v, input logic [2:0] c, input logic [5:0] fl);
    n_vec++;
    $display("%-12s dout=%02h valid=%0b count=%0d flags=%06b", tag, d, v, c, fl);
    if (e.chk_dout) cmp_field(tag, "dout", int'(d), int'(e.dout));
    cmp_field(tag, "valid", int'(v), int'(e.valid));
    cmp_field(tag, "count", int'(c), int'(e.count));
    for (int i = 0; i < 6; i++) begin
      cmp_field(tag, fl_name[i], int'(fl[5-i]), int'(e.fl[5-i]));
    end
  endtask

  initial begin
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] mdout0;
    logic       mvalid0, movf0, munf0, movf1, munf1;

    // Standard mode: fill, full with read+write, drain, underflow, flush,
    // overflow (sticky), flush priority, write+read on empty.
    t0[0]  = vt(3'b000, 8'h00, ex(8'h00, 1'b0, 3'd0, 6'b010100, 1'b1));
    t0[1]  = vt(3'b100, 8'h11, ex(8'h00, 1'b0, 3'd1, 6'b000100, 1'b1));
    t0[2]  = vt(3'b100, 8'h22, ex(8'h00, 1'b0, 3'd2, 6'b000000, 1'b1));
    t0[3]  = vt(3'b100, 8'h33, ex(8'h00, 1'b0, 3'd3, 6'b001000, 1'b1));
    t0[4]  = vt(3'b100, 8'h44, ex(8'h00, 1'b0, 3'd4, 6'b101000, 1'b1));
    t0[5]  = vt(3'b110, 8'h55, ex(8'h11, 1'b1, 3'd4, 6'b101000, 1'b1));
    t0[6]  = vt(3'b010, 8'h00, ex(8'h22, 1'b1, 3'd3, 6'b001000, 1'b1));
    t0[7]  = vt(3'b010, 8'h00, ex(8'h33, 1'b1, 3'd2, 6'b000000, 1'b1));
    t0[8]  = vt(3'b010, 8'h00, ex(8'h44, 1'b1, 3'd1, 6'b000100, 1'b1));
    t0[9]  = vt(3'b010, 8'h00, ex(8'h55, 1'b1, 3'd0, 6'b010100, 1'b1));
    t0[10] = vt(3'b010, 8'h00, ex(8'h55, 1'b0, 3'd0, 6'b010101, 1'b1));
    t0[11] = vt(3'b001, 8'h00, ex(8'h55, 1'b0, 3'd0, 6'b010100, 1'b1));
    t0[12] = vt(3'b100, 8'h01, ex(8'h55, 1'b0, 3'd1, 6'b000100, 1'b1));
    t0[13] = vt(3'b100, 8'h02, ex(8'h55, 1'b0, 3'd2, 6'b000000, 1'b1));
    t0[14] = vt(3'b100, 8'h03, ex(8'h55, 1'b0, 3'd3, 6'b001000, 1'b1));
    t0[15] = vt(3'b100, 8'h04, ex(8'h55, 1'b0, 3'd4, 6'b101000, 1'b1));
    t0[16] = vt(3'b100, 8'h05, ex(8'h55, 1'b0, 3'd4, 6'b101010, 1'b1));
    t0[17] = vt(3'b100, 8'h06, ex(8'h55, 1'b0, 3'd4, 6'b101010, 1'b1));
    t0[18] = vt(3'b111, 8'h07, ex(8'h55, 1'b0, 3'd0, 6'b010100, 1'b1));
    t0[19] = vt(3'b110, 8'h66, ex(8'h55, 1'b0, 3'd1, 6'b000101, 1'b1));
    t0[20] = vt(3'b010, 8'h00, ex(8'h66, 1'b1, 3'd0, 6'b010101, 1'b1));
    t0[21] = vt(3'b000, 8'h00, ex(8'h66, 1'b0, 3'd0, 6'b010101, 1'b1));
    t0[22] = vt(3'b001, 8'h00, ex(8'h66, 1'b0, 3'd0, 6'b010100, 1'b1));

    // FWFT: bypass on first write, fill to CAP=5, overflow, full pop+write,
    // back-to-back pops, underflow, pop+write with only the output stage busy.
    t1[0]  = vt(3'b000, 8'h00, ex(8'h00, 1'b0, 3'd0, 6'b010100, 1'b1));
    t1[1]  = vt(3'b100, 8'hA0, ex(8'hA0, 1'b1, 3'd1, 6'b000100, 1'b1));
    t1[2]  = vt(3'b100, 8'hA1, ex(8'hA0, 1'b1, 3'd2, 6'b000000, 1'b1));
    t1[3]  = vt(3'b100, 8'hA2, ex(8'hA0, 1'b1, 3'd3, 6'b000000, 1'b1));
    t1[4]  = vt(3'b100, 8'hA3, ex(8'hA0, 1'b1, 3'd4, 6'b001000, 1'b1));
    t1[5]  = vt(3'b100, 8'hA4, ex(8'hA0, 1'b1, 3'd5, 6'b101000, 1'b1));
    t1[6]  = vt(3'b100, 8'hA5, ex(8'hA0, 1'b1, 3'd5, 6'b101010, 1'b1));
    t1[7]  = vt(3'b110, 8'hA6, ex(8'hA1, 1'b1, 3'd5, 6'b101010, 1'b1));
    t1[8]  = vt(3'b010, 8'h00, ex(8'hA2, 1'b1, 3'd4, 6'b001010, 1'b1));
    t1[9]  = vt(3'b010, 8'h00, ex(8'hA3, 1'b1, 3'd3, 6'b000010, 1'b1));
    t1[10] = vt(3'b010, 8'h00, ex(8'hA4, 1'b1, 3'd2, 6'b000010, 1'b1));
    t1[11] = vt(3'b010, 8'h00, ex(8'hA6, 1'b1, 3'd1, 6'b000110, 1'b1));
    t1[12] = vt(3'b010, 8'h00, ex(8'h00, 1'b0, 3'd0, 6'b010110, 1'b0));
    t1[13] = vt(3'b010, 8'h00, ex(8'h00, 1'b0, 3'd0, 6'b010111, 1'b0));
    t1[14] = vt(3'b001, 8'h00, ex(8'h00, 1'b0, 3'd0, 6'b010100, 1'b0));
    t1[15] = vt(3'b110, 8'hB0, ex(8'hB0, 1'b1, 3'd1, 6'b000101, 1'b1));
    t1[16] = vt(3'b110, 8'hB1, ex(8'hB1, 1'b1, 3'd1, 6'b000101, 1'b1));
    t1[17] = vt(3'b110, 8'hB2, ex(8'hB2, 1'b1, 3'd1, 6'b000101, 1'b1));
    t1[18] = vt(3'b100, 8'hB3, ex(8'hB2, 1'b1, 3'd2, 6'b000001, 1'b1));
    t1[19] = vt(3'b010, 8'h00, ex(8'hB3, 1'b1, 3'd1, 6'b000101, 1'b1));
    t1[20] = vt(3'b001, 8'h00, ex(8'h00, 1'b0, 3'd0, 6'b010100, 1'b0));

    rst_n = 1'b0;
    {wr0, rd0, clr0} = 3'b000; din0 = 8'h00;
    {wr1, rd1, clr1} = 3'b000; din1 = 8'h00;

    // Reset values while reset is held.
    #3;
    check("rst_d0", ex(8'h00, 1'b0, 3'd0, 6'b010100, 1'b1), dout0, valid0, count0, fl0);
    check("rst_d1", ex(8'h00, 1'b0, 3'd0, 6'b010100, 1'b1), dout1, valid1, count1, fl1);
    #9 rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      {wr0, rd0, clr0} = t0[i].ctl;
      din0 = t0[i].din;
      @(posedge clk); #1;
      check($sformatf("d0_v%0d", i), t0[i].e, dout0, valid0, count0, fl0);
    end
    {wr0, rd0, clr0} = 3'b000;

    for (int i = 0; i < 21; i++) begin
      {wr1, rd1, clr1} = t1[i].ctl;
      din1 = t1[i].din;
      @(posedge clk); #1;
      check($sformatf("d1_v%0d", i), t1[i].e, dout1, valid1, count1, fl1);
    end
    {wr1, rd1, clr1} = 3'b000;

    // Reset asserted mid-burst clears state without waiting for a clock edge.
    wr0 = 1'b1; wr1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din0 = 8'hC1 + 8'(k);
      din1 = 8'hC1 + 8'(k);
      @(posedge clk); #1;
    end
    check("burst_d0", ex(8'h66, 1'b0, 3'd3, 6'b001000, 1'b1), dout0, valid0, count0, fl0);
    check("burst_d1", ex(8'hC1, 1'b1, 3'd3, 6'b000000, 1'b1), dout1, valid1, count1, fl1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_d0", ex(8'h00, 1'b0, 3'd0, 6'b010100, 1'b1), dout0, valid0, count0, fl0);
    check("arst_d1", ex(8'h00, 1'b0, 3'd0, 6'b010100, 1'b1), dout1, valid1, count1, fl1);
    wr0 = 1'b0; wr1 = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_d0", ex(8'h00, 1'b0, 3'd0, 6'b010100, 1'b1), dout0, valid0, count0, fl0);
    check("post_d1", ex(8'h00, 1'b0, 3'd0, 6'b010100, 1'b1), dout1, valid1, count1, fl1);

    // Random traffic against queue scoreboards; phases alternate fill/drain bias.
    mdout0 = 8'h00; mvalid0 = 1'b0; movf0 = 1'b0; munf0 = 1'b0;
    movf1 = 1'b0; munf1 = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      int  p_wr, p_rd;
      bit  rd_ok, wr_ok;
      logic [7:0] hd1;
      p_wr = ((c / 100) % 2 == 0) ? 75 : 30;
      p_rd = ((c / 100) % 2 == 0) ? 30 : 75;
      wr0  = ($urandom_range(0, 99) < p_wr);
      rd0  = ($urandom_range(0, 99) < p_rd);
      din0 = 8'($urandom_range(0, 255));
      wr1  = ($urandom_range(0, 99) < p_wr);
      rd1  = ($urandom_range(0, 99) < p_rd);
      din1 = 8'($urandom_range(0, 255));
      @(posedge clk); #1;

      // Standard-mode model.
      rd_ok = rd0 && (q0.size() > 0);
      wr_ok = wr0 && ((q0.size() < 4) || rd_ok);
      if (rd0 && !rd_ok) munf0 = 1'b1;
      if (wr0 && !wr_ok) movf0 = 1'b1;
      if (rd_ok) begin
        mdout0  = q0.pop_front();
        mvalid0 = 1'b1;
      end else begin
        mvalid0 = 1'b0;
      end
      if (wr_ok) q0.push_back(din0);
      check($sformatf("rnd0_%0d", c),
            ex(mdout0, mvalid0, 3'(q0.size()),
               {q0.size() == 4, q0.size() == 0, q0.size() >= 3, q0.size() <= 1, movf0, munf0}, 1'b1),
            dout0, valid0, count0, fl0);

      // FWFT model: the head of the queue is what dout presents.
      rd_ok = rd1 && (q1.size() > 0);
      wr_ok = wr1 && ((q1.size() < 5) || rd_ok);
      if (rd1 && !rd_ok) munf1 = 1'b1;
      if (wr1 && !wr_ok) movf1 = 1'b1;
      if (rd_ok) void'(q1.pop_front());
      if (wr_ok) q1.push_back(din1);
      hd1 = (q1.size() > 0) ? q1[0] : 8'h00;
      check($sformatf("rnd1_%0d", c),
            ex(hd1, q1.size() > 0, 3'(q1.size()),
               {q1.size() == 5, q1.size() == 0, q1.size() >= 4, q1.size() <= 1, movf1, munf1},
               q1.size() > 0),
            dout1, valid1, count1, fl1);
    end
    {wr0, rd0, wr1, rd1} = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fifo_sync_flags.md
# fifo_sync_flags

Parametrised single-clock FIFO, the next generation of the team's BRAM-backed FIFO. It adds a selectable first-word-fall-through (FWFT) mode, read and write in the same cycle while full, an occupancy count, programmable almost-full and almost-empty thresholds, sticky overflow/underflow error flags, and a synchronous flush. It sits between the USB endpoint logic and the packet/UART datapaths wherever buffering plus back-pressure information is needed.

## Interface
- DW, 8, data width in bits
- AW, 9, address width; memory depth is 2^AW entries
- FWFT, 0, 0 = standard mode, 1 = first-word-fall-through mode
- AF_LVL, 2^AW-4, almost_full asserts when count >= AF_LVL; legal range 1..CAP
- AE_LVL, 4, almost_empty asserts when count <= AE_LVL; legal range 0..CAP-1

Ports (CAP is 2^AW when FWFT=0, and 2^AW+1 when FWFT=1):
- clk  in  1  clock; all logic uses the rising edge
- rst_n  in  1  reset; one clock, asynchronous assertion, active-low
- clr  in  1  synchronous flush
- wr  in  1  write request
- din  in  DW  write data
- rd  in  1  read request (FWFT=0) or pop (FWFT=1)
- dout  out  DW  read data
- valid  out  1  dout qualifier
- full  out  1  count == CAP
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LVL
- almost_empty  out  1  count <= AE_LVL
- count  out  AW+1  current occupancy, including the FWFT output stage
- overflow  out  1  sticky: a write was dropped
- underflow  out  1  sticky: a read was issued while empty

## Operation
- Storage is a 2^AW x DW memory with a synchronous read, inferred as block RAM.
- Pointers are AW+1 bits wide; the extra MSB distinguishes wrap phase. Occupancy is tracked in a registered count.
- A write is accepted when wr && (!full || pop). Here pop means the read accepted in the same cycle.
- A write that is not accepted (wr && full && !pop) sets overflow and leaves storage unchanged.
- FWFT=0 behaviour:
  - A read is accepted when rd && !empty.
  - An accepted read loads dout with the head entry and asserts valid for exactly one cycle.
  - dout holds its last value when no read is accepted.
  - rd && empty sets underflow. valid stays 0.
- FWFT=1 behaviour:
  - valid means the head entry is currently presented on dout.
  - A pop is accepted when rd && valid.
  - After a pop, the next entry (if any) appears on dout in the following cycle, so a pop every cycle is sustainable.
  - A write to a completely empty FIFO bypasses the memory and goes straight to the output stage.
  - rd && !valid sets underflow.
- Count update per cycle: count += (write accepted) - (read/pop accepted). A simultaneous accepted write and read leaves count unchanged.
- All flags are decoded from registered state only. There is no combinational path from wr/rd to any flag.
- clr has priority over wr and rd in the same cycle. It zeroes both pointers, count, valid, overflow and underflow. dout is unchanged.
- Once set, overflow and underflow stay set until clr or reset.

## Timing
- Reset values: dout=0, valid=0, empty=1, full=0, almost_full=0, almost_empty=1, count=0, overflow=0, underflow=0. Memory contents are undefined.
- Reset may assert mid-transfer. All state returns to the reset values immediately, and any transfer in progress is discarded.
- Write accepted at edge N: count, empty, full and the almost flags reflect it in cycle N+1.
- FWFT=0, read accepted at edge N: dout is valid and valid=1 during cycle N+1 (1-cycle latency).
- FWFT=1, write to an empty FIFO at edge N: valid=1 with that data on dout in cycle N+1.
- FWFT=1 refill: after a pop at edge N, the next entry is on dout in cycle N+1 whenever the memory is non-empty.
- Write to empty with rd in the same cycle, FWFT=0: the read is not accepted (empty), underflow is set, and the write is stored.
- Full with wr && rd in the same cycle: both are accepted, count stays at CAP, and no overflow is flagged.
- Wrap-around: pointer MSBs differ when full; empty and full are also consistent with count at every wrap.
- Overflow and underflow set in cycle N+1 after the offending edge N.

## Test plan
- Reset, then idle: all outputs match the reset values. Asserting rst_n=0 mid-burst returns count to 0 asynchronously.
- FWFT=0, AW=2, write 0x11,0x22,0x33,0x44: full=1 and count=4. Then read 4 times: dout = 0x11..0x44 with one valid pulse each, then empty=1.
- FWFT=0, full, wr=1 with din=0x55 and rd=1: dout=0x11, count stays 4, overflow=0. The next three reads return 0x22, 0x33, 0x44 and the fourth returns 0x55.
- FWFT=1, AW=2: write 0xA0 → dout=0xA0 with valid=1 one cycle later. Then fill to count=5=CAP. Then pop every cycle: dout runs through consecutive entries with no gaps.
- Overflow/underflow: write 5 entries at AW=2, FWFT=0 → overflow=1, count=4. clr → overflow=0, count=0. rd on empty → underflow=1.
- Thresholds with AF_LVL=3, AE_LVL=1: almost_empty holds at count 0..1, almost_full asserts at count 3. Run 1000 random wr/rd cycles and check against a scoreboard.
